// File: rtl/alu_op_sequencer.sv
// Sequences one arithmetic operation: latch operands, pulse the FPU, then stream the result MSB first.
// Optional FPU watchdog enabled by defining ALU_SEQ_TIMEOUT_EN.
module alu_op_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 1023,
    parameter int unsigned NUM_TX_BYTES   = 4
) (
    input  logic        i_clk_50m,
    input  logic        i_rst_n,
    input  logic        i_ready,
    input  logic [31:0] i_num1,
    input  logic [31:0] i_num2,
    input  logic [1:0]  i_op_sel,
    output logic        o_fpu_start,
    output logic [1:0]  o_fpu_op,
    output logic [31:0] o_fpu_a,
    output logic [31:0] o_fpu_b,
    input  logic        i_fpu_done,
    input  logic [31:0] i_fpu_result,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_wr_en,
    input  logic        i_tx_busy,
    output logic [31:0] o_result,
    output logic        o_busy,
    output logic        o_overrun,
    output logic        o_timeout
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] ISSUE      = 3'd1;
    localparam logic [2:0] WAIT_FPU   = 3'd2;
    localparam logic [2:0] LOAD_BYTE  = 3'd3;
    localparam logic [2:0] WAIT_TX_HI = 3'd4;
    localparam logic [2:0] WAIT_TX_LO = 3'd5;

    localparam int unsigned IdxW = $clog2(NUM_TX_BYTES + 1);

    logic [2:0]      r_state;
    logic [2:0]      w_state_next;
    logic [1:0]      r_fpu_op;
    logic [31:0]     r_fpu_a;
    logic [31:0]     r_fpu_b;
    logic [31:0]     r_result;
    logic [31:0]     r_shift;
    logic [IdxW-1:0] r_idx;
    logic [IdxW-1:0] w_idx_inc;
    logic            r_overrun;
    logic            w_accept;
    logic            w_done_ok;
    logic            w_byte_done;
    logic            w_last_byte;
    logic            w_tmo_hit;

    assign w_accept    = (r_state == IDLE) && i_ready;
    assign w_done_ok   = (r_state == WAIT_FPU) && i_fpu_done;
    assign w_byte_done = (r_state == WAIT_TX_LO) && !i_tx_busy;
    assign w_idx_inc   = r_idx + 1'b1;
    assign w_last_byte = (w_idx_inc == IdxW'(NUM_TX_BYTES));

`ifdef ALU_SEQ_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] r_tmo_cnt;
    logic            r_timeout;

    // Fires on the last allowed WAIT_FPU cycle so exactly TIMEOUT_CYCLES cycles are spent waiting.
    assign w_tmo_hit = (r_state == WAIT_FPU) && !i_fpu_done &&
                       (r_tmo_cnt == CntW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tmo_cnt <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state == WAIT_FPU) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end else begin
                r_tmo_cnt <= '0;
            end
            if (w_accept) begin
                r_timeout <= 1'b0;
            end else if (w_tmo_hit) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign o_timeout = r_timeout;
`else
    assign w_tmo_hit = 1'b0;
    assign o_timeout = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (i_ready) begin
                    w_state_next = ISSUE;
                end
            end
            ISSUE: begin
                w_state_next = WAIT_FPU;
            end
            WAIT_FPU: begin
                if (i_fpu_done) begin
                    w_state_next = LOAD_BYTE;
                end else if (w_tmo_hit) begin
                    w_state_next = IDLE;
                end
            end
            LOAD_BYTE: begin
                // Hold off the strobe until the transmitter is free.
                if (!i_tx_busy) begin
                    w_state_next = WAIT_TX_HI;
                end
            end
            WAIT_TX_HI: begin
                if (i_tx_busy) begin
                    w_state_next = WAIT_TX_LO;
                end
            end
            WAIT_TX_LO: begin
                if (!i_tx_busy) begin
                    w_state_next = w_last_byte ? IDLE : LOAD_BYTE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fpu_op  <= 2'b00;
            r_fpu_a   <= '0;
            r_fpu_b   <= '0;
            r_result  <= '0;
            r_shift   <= '0;
            r_idx     <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_accept) begin
                r_fpu_op  <= i_op_sel;
                r_fpu_a   <= i_num1;
                r_fpu_b   <= i_num2;
                r_overrun <= 1'b0;
            end else if (i_ready) begin
                r_overrun <= 1'b1;
            end
            if (w_done_ok) begin
                r_result <= i_fpu_result;
                r_shift  <= i_fpu_result;
                r_idx    <= '0;
            end else if (w_byte_done) begin
                r_shift <= {r_shift[23:0], 8'h00};
                r_idx   <= w_idx_inc;
            end
        end
    end

    assign o_fpu_start = (r_state == ISSUE);
    assign o_tx_wr_en  = (r_state == LOAD_BYTE) && !i_tx_busy;
    assign o_tx_data   = r_shift[31:24];
    assign o_fpu_op    = r_fpu_op;
    assign o_fpu_a     = r_fpu_a;
    assign o_fpu_b     = r_fpu_b;
    assign o_result    = r_result;
    assign o_busy      = (r_state != IDLE);
    assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with behavioural FPU and transmitter models.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ready = 1'b0;
    logic [31:0] num1 = '0;
    logic [31:0] num2 = '0;
    logic [1:0]  op_sel = 2'b00;
    logic        fpu_start;
    logic [1:0]  fpu_op;
    logic [31:0] fpu_a;
    logic [31:0] fpu_b;
    logic        fpu_done = 1'b0;
    logic [31:0] fpu_result = '0;
    logic [7:0]  tx_data;
    logic        tx_wr_en;
    logic        tx_busy = 1'b0;
    logic [31:0] result;
    logic        busy;
    logic        overrun;
    logic        timeout;

    alu_op_sequencer dut (
        .i_clk_50m   (clk),
        .i_rst_n     (rst_n),
        .i_ready     (ready),
        .i_num1      (num1),
        .i_num2      (num2),
        .i_op_sel    (op_sel),
        .o_fpu_start (fpu_start),
        .o_fpu_op    (fpu_op),
        .o_fpu_a     (fpu_a),
        .o_fpu_b     (fpu_b),
        .i_fpu_done  (fpu_done),
        .i_fpu_result(fpu_result),
        .o_tx_data   (tx_data),
        .o_tx_wr_en  (tx_wr_en),
        .i_tx_busy   (tx_busy),
        .o_result    (result),
        .o_busy      (busy),
        .o_overrun   (overrun),
        .o_timeout   (timeout)
    );

    always #10 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_start = 0;
    int n_wr = 0;
    int fpu_lat = 5;
    int tx_len = 3;
    bit fpu_en = 1'b1;

    logic [65:0] q_ops[$];
    logic [31:0] q_res[$];
    logic [7:0]  q_bytes[$];
    int          q_wr_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: event occurred, required none", name);
    endtask

    // FPU model: checks latched operands at the start pulse, answers fpu_lat cycles later.
    initial begin
        logic [65:0] e;
        logic [31:0] r;
        forever begin
            @(negedge clk);
            if (fpu_start === 1'b1) begin
                n_start++;
                if (q_ops.size() == 0) begin
                    fail("unexpected_fpu_start");
                end else begin
                    e = q_ops.pop_front();
                    check("fpu_op", {30'd0, fpu_op}, {30'd0, e[65:64]});
                    check("fpu_a", fpu_a, e[63:32]);
                    check("fpu_b", fpu_b, e[31:0]);
                end
                if (fpu_en && q_res.size() > 0) begin
                    r = q_res.pop_front();
                    repeat (fpu_lat) @(negedge clk);
                    fpu_result = r;
                    fpu_done   = 1'b1;
                    @(negedge clk);
                    fpu_done   = 1'b0;
                end
            end
        end
    end

    // Transmitter model and byte monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_wr_en === 1'b1) begin
                n_wr++;
                q_wr_cyc.push_back(cyc);
                if (q_bytes.size() == 0) fail("unexpected_tx_byte");
                else check("tx_byte", {24'd0, tx_data}, {24'd0, q_bytes.pop_front()});
                @(negedge clk);
                tx_busy = 1'b1;
                repeat (tx_len) @(negedge clk);
                tx_busy = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (tx_wr_en === 1'b1 && tx_busy === 1'b1) fail("tx_wr_en_while_busy");
    end

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                         input logic [31:0] res, input bit with_res);
        q_ops.push_back({op, a, b});
        if (with_res) begin
            q_res.push_back(res);
            for (int i = 3; i >= 0; i--) q_bytes.push_back(res[8*i +: 8]);
        end
        @(posedge clk);
        #1;
        num1   = a;
        num2   = b;
        op_sel = op;
        ready  = 1'b1;
        @(posedge clk);
        #1;
        ready  = 1'b0;
    endtask

    task automatic pulse_ready(input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        num1  = a;
        num2  = b;
        ready = 1'b1;
        @(posedge clk);
        #1;
        ready = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_within_budget", {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_wr_busy(input int wr_target, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(n_wr == wr_target && tx_busy === 1'b1) && n < budget);
        check("wait_tx_byte_reached", n_wr, wr_target);
    endtask

    initial begin
        int t0, s0, w0, n;

        // Reset state
        #5;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_fpu_start", {31'd0, fpu_start}, 32'd0);
        check("rst_tx_wr_en", {31'd0, tx_wr_en}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_fpu_a", fpu_a, 32'd0);
        check("rst_flags", {30'd0, overrun, timeout}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 1.0 + 2.0 = 3.0 with first-byte latency check
        tx_len = 3;
        q_wr_cyc.delete();
        do_op(32'h3F80_0000, 32'h4000_0000, 2'b00, 32'h4040_0000, 1'b1);
        t0 = cyc - 1;
        wait_idle(200);
        check("add_result", result, 32'h4040_0000);
        check("add_bytes_sent", n_wr, 4);
        check("add_start_count", n_start, 1);
        check("add_latency", (q_wr_cyc.size() > 0) ? q_wr_cyc[0] - t0 : -1, fpu_lat + 2);
        check("add_overrun", {31'd0, overrun}, 32'd0);

        // Ready dropped during WAIT_TX_LO of byte 2
        s0 = n_start;
        w0 = n_wr;
        do_op(32'h4000_0000, 32'h3F80_0000, 2'b01, 32'h3F80_0000, 1'b1);
        wait_wr_busy(w0 + 2, 200);
        pulse_ready(32'hAAAA_AAAA, 32'h5555_5555);
        check("ovr_set", {31'd0, overrun}, 32'd1);
        check("ovr_busy", {31'd0, busy}, 32'd1);
        wait_idle(200);
        check("ovr_bytes_sent", n_wr - w0, 4);
        check("ovr_no_restart", n_start - s0, 1);
        check("ovr_operand_kept", fpu_a, 32'h4000_0000);
        check("ovr_sticky", {31'd0, overrun}, 32'd1);

        // 2.0 * 3.0 with slow transmitter; overrun clears on accept
        tx_len = 40;
        w0 = n_wr;
        do_op(32'h4000_0000, 32'h4040_0000, 2'b10, 32'h40C0_0000, 1'b1);
        check("ovr_cleared", {31'd0, overrun}, 32'd0);
        wait_idle(400);
        check("mul_result", result, 32'h40C0_0000);
        check("mul_bytes_sent", n_wr - w0, 4);

        // Pass-through with ready coincident with fpu_done
        tx_len = 1;
        fpu_lat = 3;
        s0 = n_start;
        do_op(32'hDEAD_BEEF, 32'h0000_0001, 2'b11, 32'hDEAD_BEEF, 1'b1);
        n = 0;
        while (fpu_done !== 1'b1 && n < 2000) begin
            #1;
            n++;
        end
        check("pass_done_seen", {31'd0, fpu_done}, 32'd1);
        #1;
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        wait_idle(200);
        check("pass_result", result, 32'hDEAD_BEEF);
        check("pass_overrun", {31'd0, overrun}, 32'd1);
        check("pass_start_count", n_start - s0, 1);

        // fpu_done while idle is ignored
        w0 = n_wr;
        @(negedge clk);
        fpu_result = 32'h1111_1111;
        fpu_done   = 1'b1;
        @(negedge clk);
        fpu_done   = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_done_result", result, 32'hDEAD_BEEF);
        check("idle_done_busy", {31'd0, busy}, 32'd0);
        check("idle_done_no_tx", n_wr - w0, 0);

        // Reset in the middle of byte 1, then a clean operation
        tx_len = 5;
        fpu_lat = 5;
        w0 = n_wr;
        do_op(32'h3F80_0000, 32'h3F80_0000, 2'b00, 32'h4000_0000, 1'b1);
        wait_wr_busy(w0 + 1, 200);
        #3;
        rst_n = 1'b0;
        #1;
        check("amid_rst_busy", {31'd0, busy}, 32'd0);
        check("amid_rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("amid_rst_result", result, 32'd0);
        check("amid_rst_fpu_a", fpu_a, 32'd0);
        check("amid_rst_fpu_b", fpu_b, 32'd0);
        check("amid_rst_strobes", {30'd0, tx_wr_en, fpu_start}, 32'd0);
        q_bytes.delete();
        w0 = n_wr;
        repeat (3) @(negedge clk);
        check("amid_rst_no_tx", n_wr - w0, 0);
        rst_n = 1'b1;
        do_op(32'h1234_0000, 32'h0000_5678, 2'b00, 32'h1234_5678, 1'b1);
        wait_idle(300);
        check("post_rst_result", result, 32'h1234_5678);
        check("post_rst_bytes", n_wr - w0, 4);

        // FPU never answers
        fpu_en = 1'b0;
        w0 = n_wr;
        do_op(32'h0BAD_F00D, 32'h0000_0002, 2'b10, 32'h0, 1'b0);
        n = 0;
`ifdef ALU_SEQ_TIMEOUT_EN
        while (busy !== 1'b0 && n < 1200) begin
            @(negedge clk);
            n++;
        end
        check("tmo_cycles_to_idle", n, 1025);
        check("tmo_flag", {31'd0, timeout}, 32'd1);
        check("tmo_no_tx", n_wr - w0, 0);
        check("tmo_result_kept", result, 32'h1234_5678);
`else
        repeat (1100) @(negedge clk);
        check("notmo_still_busy", {31'd0, busy}, 32'd1);
        check("notmo_flag", {31'd0, timeout}, 32'd0);
        check("notmo_no_tx", n_wr - w0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
`endif
        fpu_en = 1'b1;
        repeat (2) @(negedge clk);
        check("sb_bytes_drained", q_bytes.size(), 0);
        check("sb_ops_drained", q_ops.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, bad=%0d", bad + 1);
        $fatal(1, "global timeout");
    end

endmodule
